// File: rtl/alu_golden_checker.sv
// alu_golden_checker
// Realigns golden results with the returned results of a pipelined ALU whose
// latency is not fixed but is in order. Each issued golden value is queued in
// a small FIFO. Each returned result pops the oldest entry and is compared
// against it. A tolerance on the raw bit-pattern distance is applied.
// The checker also keeps saturating statistics and sticky protocol errors.
//
// Optional build macro: ALU_GOLDEN_CHECKER_FIRST_ERR_EN
//   When it is defined, the checker records the first mismatching entry
//   (operand, result, golden value and index) on the FE_* outputs, and each
//   FIFO entry also stores the issued operand.
//   When it is undefined, only golden values are queued and the FE_* ports
//   are absent.

module alu_golden_checker #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int TOLERANCE  = 0,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CLEAR,
   input  logic                  EN,
   input  logic [DATA_WIDTH-1:0] DIN,
   input  logic [DATA_WIDTH-1:0] DIN_GOLDEN,
   output logic                  READY,
   input  logic                  RES_VALID,
   input  logic [DATA_WIDTH-1:0] RES_DATA,
   output logic                  OE,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic [DATA_WIDTH-1:0] DOUT_GOLDEN,
   output logic                  MISMATCH,
   output logic [CNT_WIDTH-1:0]  TEST_COUNT,
   output logic [CNT_WIDTH-1:0]  ERR_COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
`ifdef ALU_GOLDEN_CHECKER_FIRST_ERR_EN
   ,
   output logic                  FE_VALID,
   output logic [DATA_WIDTH-1:0] FE_DIN,
   output logic [DATA_WIDTH-1:0] FE_DOUT,
   output logic [DATA_WIDTH-1:0] FE_GOLDEN,
   output logic [CNT_WIDTH-1:0]  FE_INDEX
`endif
);

   localparam int                  LP_AW     = $clog2(FIFO_DEPTH);
   localparam logic [LP_AW:0]      LP_DEPTH  = (LP_AW+1)'(FIFO_DEPTH);
   localparam logic [DATA_WIDTH:0] LP_TOL    = (DATA_WIDTH+1)'(TOLERANCE);
   localparam bit                  LP_TOL_EN = (TOLERANCE > 0);

   // FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] r_mem_gold [FIFO_DEPTH];
   logic [LP_AW-1:0]      r_wr_ptr;
   logic [LP_AW-1:0]      r_rd_ptr;
   logic [LP_AW:0]        r_count;

   // registered outputs
   logic                  r_oe;
   logic [DATA_WIDTH-1:0] r_dout;
   logic [DATA_WIDTH-1:0] r_dout_golden;
   logic                  r_mismatch;
   logic [CNT_WIDTH-1:0]  r_test_cnt;
   logic [CNT_WIDTH-1:0]  r_err_cnt;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_ready;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_result;
   logic                  w_underflow;
   logic                  w_overflow;
   logic [DATA_WIDTH-1:0] w_golden;
   logic [DATA_WIDTH:0]   w_diff;
   logic                  w_cmp_mismatch;
   logic                  w_mismatch;

   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);

   // A pop in the same cycle frees a slot, so a push is accepted even when full.
   assign w_ready = !w_full || RES_VALID;

   // CLEAR takes priority: same-cycle issues and results are ignored.
   assign w_push      = EN && w_ready && !CLEAR;
   assign w_overflow  = EN && !w_ready && !CLEAR;
   assign w_result    = RES_VALID && !CLEAR;
   // A result never bypasses a same-cycle push; an empty FIFO is an underflow.
   assign w_pop       = w_result && !w_empty;
   assign w_underflow = w_result && w_empty;

   assign w_golden = w_empty ? '0 : r_mem_gold[r_rd_ptr];

   // absolute distance of raw bit patterns, tolerance applied only within one sign
   always_comb begin
      w_diff = '0;
      w_cmp_mismatch = 1'b0;
      if (RES_DATA >= w_golden)
         w_diff = {1'b0, RES_DATA} - {1'b0, w_golden};
      else
         w_diff = {1'b0, w_golden} - {1'b0, RES_DATA};
      if (LP_TOL_EN && (RES_DATA[DATA_WIDTH-1] != w_golden[DATA_WIDTH-1]))
         w_cmp_mismatch = (RES_DATA != w_golden);
      else
         w_cmp_mismatch = (w_diff > LP_TOL);
   end

   assign w_mismatch = w_underflow || w_cmp_mismatch;

   // FIFO payload write (no reset needed, validity is tracked by r_count)
   always_ff @(posedge CLK) begin
      if (w_push)
         r_mem_gold[r_wr_ptr] <= DIN_GOLDEN;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (CLEAR) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // compare result register, statistics and sticky errors
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_oe          <= 1'b0;
         r_dout        <= '0;
         r_dout_golden <= '0;
         r_mismatch    <= 1'b0;
         r_test_cnt    <= '0;
         r_err_cnt     <= '0;
         r_overflow    <= 1'b0;
         r_underflow   <= 1'b0;
      end else if (CLEAR) begin
         r_oe        <= 1'b0;
         r_mismatch  <= 1'b0;
         r_test_cnt  <= '0;
         r_err_cnt   <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_oe       <= w_result;
         r_mismatch <= 1'b0;
         if (w_result) begin
            r_dout        <= RES_DATA;
            r_dout_golden <= w_golden;
            r_mismatch    <= w_mismatch;
            if (r_test_cnt != '1)
               r_test_cnt <= r_test_cnt + 1'b1;
            if (w_mismatch && (r_err_cnt != '1))
               r_err_cnt <= r_err_cnt + 1'b1;
         end
         if (w_overflow)
            r_overflow <= 1'b1;
         if (w_underflow)
            r_underflow <= 1'b1;
      end
   end

   assign READY       = w_ready;
   assign OE          = r_oe;
   assign DOUT        = r_dout;
   assign DOUT_GOLDEN = r_dout_golden;
   assign MISMATCH    = r_mismatch;
   assign TEST_COUNT  = r_test_cnt;
   assign ERR_COUNT   = r_err_cnt;
   assign OVERFLOW    = r_overflow;
   assign UNDERFLOW   = r_underflow;

`ifdef ALU_GOLDEN_CHECKER_FIRST_ERR_EN
   logic [DATA_WIDTH-1:0] r_mem_din [FIFO_DEPTH];
   logic                  r_fe_valid;
   logic [DATA_WIDTH-1:0] r_fe_din;
   logic [DATA_WIDTH-1:0] r_fe_dout;
   logic [DATA_WIDTH-1:0] r_fe_golden;
   logic [CNT_WIDTH-1:0]  r_fe_index;
   logic [DATA_WIDTH-1:0] w_head_din;

   assign w_head_din = w_empty ? '0 : r_mem_din[r_rd_ptr];

   // operand payload travels alongside the golden value
   always_ff @(posedge CLK) begin
      if (w_push)
         r_mem_din[r_wr_ptr] <= DIN;
   end

   // capture the first mismatch only; index is the test count before increment
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fe_valid  <= 1'b0;
         r_fe_din    <= '0;
         r_fe_dout   <= '0;
         r_fe_golden <= '0;
         r_fe_index  <= '0;
      end else if (CLEAR) begin
         r_fe_valid  <= 1'b0;
         r_fe_din    <= '0;
         r_fe_dout   <= '0;
         r_fe_golden <= '0;
         r_fe_index  <= '0;
      end else if (w_result && w_mismatch && !r_fe_valid) begin
         r_fe_valid  <= 1'b1;
         r_fe_din    <= w_head_din;
         r_fe_dout   <= RES_DATA;
         r_fe_golden <= w_golden;
         r_fe_index  <= r_test_cnt;
      end
   end

   assign FE_VALID  = r_fe_valid;
   assign FE_DIN    = r_fe_din;
   assign FE_DOUT   = r_fe_dout;
   assign FE_GOLDEN = r_fe_golden;
   assign FE_INDEX  = r_fe_index;
`endif

endmodule

// File: tb/tb_alu_golden_checker.sv
// Directed bench for alu_golden_checker (DATA_WIDTH 32, depth 8, tolerance 2).
module tb_alu_golden_checker;

   logic        CLK;
   logic        RST;
   logic        CLEAR;
   logic        EN;
   logic [31:0] DIN;
   logic [31:0] DIN_GOLDEN;
   logic        READY;
   logic        RES_VALID;
   logic [31:0] RES_DATA;
   logic        OE;
   logic [31:0] DOUT;
   logic [31:0] DOUT_GOLDEN;
   logic        MISMATCH;
   logic [31:0] TEST_COUNT;
   logic [31:0] ERR_COUNT;
   logic        OVERFLOW;
   logic        UNDERFLOW;
`ifdef ALU_GOLDEN_CHECKER_FIRST_ERR_EN
   logic        FE_VALID;
   logic [31:0] FE_DIN;
   logic [31:0] FE_DOUT;
   logic [31:0] FE_GOLDEN;
   logic [31:0] FE_INDEX;
`endif

   int checks;
   int failures;

   alu_golden_checker #(
      .DATA_WIDTH(32),
      .FIFO_DEPTH(8),
      .TOLERANCE (2),
      .CNT_WIDTH (32)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CLEAR      (CLEAR),
      .EN         (EN),
      .DIN        (DIN),
      .DIN_GOLDEN (DIN_GOLDEN),
      .READY      (READY),
      .RES_VALID  (RES_VALID),
      .RES_DATA   (RES_DATA),
      .OE         (OE),
      .DOUT       (DOUT),
      .DOUT_GOLDEN(DOUT_GOLDEN),
      .MISMATCH   (MISMATCH),
      .TEST_COUNT (TEST_COUNT),
      .ERR_COUNT  (ERR_COUNT),
      .OVERFLOW   (OVERFLOW),
      .UNDERFLOW  (UNDERFLOW)
`ifdef ALU_GOLDEN_CHECKER_FIRST_ERR_EN
      ,
      .FE_VALID   (FE_VALID),
      .FE_DIN     (FE_DIN),
      .FE_DOUT    (FE_DOUT),
      .FE_GOLDEN  (FE_GOLDEN),
      .FE_INDEX   (FE_INDEX)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [31:0] din, input logic [31:0] gold,
                        input logic rv, input logic [31:0] rdata, input logic clr);
      EN = en;
      DIN = din;
      DIN_GOLDEN = gold;
      RES_VALID = rv;
      RES_DATA = rdata;
      CLEAR = clr;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      RST = 1'b1;
      idle();

      // reset state
      tick();
      tick();
      chk("rst_ready", 64'(READY), 64'd1);
      chk("rst_oe", 64'(OE), 64'd0);
      chk("rst_test_count", 64'(TEST_COUNT), 64'd0);
      chk("rst_err_count", 64'(ERR_COUNT), 64'd0);
      chk("rst_ovf", 64'(OVERFLOW), 64'd0);
      chk("rst_unf", 64'(UNDERFLOW), 64'd0);
      RST = 1'b0;
      tick();

      // exact match, latency 3: issue 1..4 (golden 2x), results 3 cycles later
      for (int c = 0; c < 8; c++) begin
         drive(c < 4, 32'(c + 1), 32'(2 * (c + 1)), (c >= 3) && (c < 7), 32'(2 * (c - 2)), 1'b0);
         tick();
         chk("lat3_oe", 64'(OE), 64'((c >= 3) && (c < 7)));
         if ((c >= 3) && (c < 7)) begin
            chk("lat3_dout", 64'(DOUT), 64'(2 * (c - 2)));
            chk("lat3_golden", 64'(DOUT_GOLDEN), 64'(2 * (c - 2)));
            chk("lat3_mismatch", 64'(MISMATCH), 64'd0);
         end
      end
      idle();
      tick();
      chk("lat3_oe_idle", 64'(OE), 64'd0);
      chk("lat3_test_count", 64'(TEST_COUNT), 64'd4);
      chk("lat3_err_count", 64'(ERR_COUNT), 64'd0);

      // tolerance 2
      drive(1'b1, 32'd10, 32'h3F80_0000, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'h0, 1'b1, 32'h3F80_0002, 1'b0);
      tick();
      chk("tol_p2_oe", 64'(OE), 64'd1);
      chk("tol_p2_mismatch", 64'(MISMATCH), 64'd0);
      drive(1'b1, 32'd11, 32'h3F80_0000, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'h0, 1'b1, 32'h3F80_0003, 1'b0);
      tick();
      chk("tol_p3_mismatch", 64'(MISMATCH), 64'd1);
      chk("tol_p3_err_count", 64'(ERR_COUNT), 64'd1);
      drive(1'b1, 32'd12, 32'h3F80_0003, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'h0, 1'b1, 32'h3F80_0001, 1'b0);
      tick();
      chk("tol_m2_mismatch", 64'(MISMATCH), 64'd0);
      drive(1'b1, 32'd13, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
      tick();
      chk("tol_sign_mismatch", 64'(MISMATCH), 64'd1);
      chk("tol_err_count", 64'(ERR_COUNT), 64'd2);
      chk("tol_test_count", 64'(TEST_COUNT), 64'd8);

      // full boundary: 8 issues, no results
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'(20 + i), 32'(100 + i), 1'b0, 32'h0, 1'b0);
         tick();
      end
      idle();
      #1;
      chk("full_ready", 64'(READY), 64'd0);
      chk("full_ovf_before", 64'(OVERFLOW), 64'd0);
      drive(1'b1, 32'd99, 32'd999, 1'b0, 32'h0, 1'b0);
      #1;
      chk("full_ready_en", 64'(READY), 64'd0);
      tick();
      chk("full_ovf", 64'(OVERFLOW), 64'd1);
      idle();
      #1;
      chk("full_ready_after_ovf", 64'(READY), 64'd0);
      drive(1'b1, 32'd28, 32'd108, 1'b1, 32'd100, 1'b0);
      #1;
      chk("full_ready_pushpop", 64'(READY), 64'd1);
      tick();
      chk("full_pp_oe", 64'(OE), 64'd1);
      chk("full_pp_golden", 64'(DOUT_GOLDEN), 64'd100);
      chk("full_pp_mismatch", 64'(MISMATCH), 64'd0);
      chk("full_pp_ovf", 64'(OVERFLOW), 64'd1);
      idle();
      #1;
      chk("full_pp_still_full", 64'(READY), 64'd0);
      for (int i = 1; i < 6; i++) begin
         drive(1'b0, 32'h0, 32'h0, 1'b1, 32'(100 + i), 1'b0);
         tick();
         chk("drain_golden", 64'(DOUT_GOLDEN), 64'(100 + i));
         chk("drain_mismatch", 64'(MISMATCH), 64'd0);
      end
      chk("drain_test_count", 64'(TEST_COUNT), 64'd14);

      // CLEAR with 3 outstanding and EN in the same cycle
      drive(1'b1, 32'd77, 32'd777, 1'b0, 32'h0, 1'b1);
      tick();
      idle();
      chk("clr_oe", 64'(OE), 64'd0);
      chk("clr_test_count", 64'(TEST_COUNT), 64'd0);
      chk("clr_err_count", 64'(ERR_COUNT), 64'd0);
      chk("clr_ovf", 64'(OVERFLOW), 64'd0);
      tick();
      chk("clr_oe_next", 64'(OE), 64'd0);

      // underflow on an empty FIFO (also proves the flush)
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h5, 1'b0);
      tick();
      idle();
      chk("unf_flag", 64'(UNDERFLOW), 64'd1);
      chk("unf_oe", 64'(OE), 64'd1);
      chk("unf_dout", 64'(DOUT), 64'h5);
      chk("unf_golden", 64'(DOUT_GOLDEN), 64'h0);
      chk("unf_mismatch", 64'(MISMATCH), 64'd1);
      chk("unf_err_count", 64'(ERR_COUNT), 64'd1);
      chk("unf_test_count", 64'(TEST_COUNT), 64'd1);

      // RST mid-stream
      drive(1'b1, 32'd1, 32'h77, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b1, 32'd2, 32'h88, 1'b0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h77, 1'b0);
      tick();
      idle();
      chk("pre_rst_oe", 64'(OE), 64'd1);
      #2;
      RST = 1'b1;
      #1;
      chk("mid_rst_oe", 64'(OE), 64'd0);
      chk("mid_rst_dout", 64'(DOUT), 64'd0);
      chk("mid_rst_test_count", 64'(TEST_COUNT), 64'd0);
      chk("mid_rst_err_count", 64'(ERR_COUNT), 64'd0);
      chk("mid_rst_unf", 64'(UNDERFLOW), 64'd0);
      chk("mid_rst_ready", 64'(READY), 64'd1);
      tick();
      RST = 1'b0;

      // push and result on empty FIFO in the same cycle: underflow, no bypass
      drive(1'b1, 32'd3, 32'h42, 1'b1, 32'h42, 1'b0);
      tick();
      chk("nobypass_unf", 64'(UNDERFLOW), 64'd1);
      chk("nobypass_golden", 64'(DOUT_GOLDEN), 64'h0);
      chk("nobypass_mismatch", 64'(MISMATCH), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h42, 1'b0);
      tick();
      idle();
      chk("after_nobypass_golden", 64'(DOUT_GOLDEN), 64'h42);
      chk("after_nobypass_mismatch", 64'(MISMATCH), 64'd0);
      chk("after_nobypass_test_count", 64'(TEST_COUNT), 64'd2);
      chk("after_nobypass_err_count", 64'(ERR_COUNT), 64'd1);

`ifdef ALU_GOLDEN_CHECKER_FIRST_ERR_EN
      // first error: mismatches on the 3rd and 5th results
      drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      chk("fe_clr_valid", 64'(FE_VALID), 64'd0);
      chk("fe_clr_din", 64'(FE_DIN), 64'd0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'(32'h31 + i), 32'(32'h200 + i), 1'b0, 32'h0, 1'b0);
         tick();
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h201, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h212, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h203, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h224, 1'b0);
      tick();
      idle();
      chk("fe_valid", 64'(FE_VALID), 64'd1);
      chk("fe_index", 64'(FE_INDEX), 64'd2);
      chk("fe_din", 64'(FE_DIN), 64'h33);
      chk("fe_dout", 64'(FE_DOUT), 64'h212);
      chk("fe_golden", 64'(FE_GOLDEN), 64'h202);
      chk("fe_err_count", 64'(ERR_COUNT), 64'd2);
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
